// File: rtl/crossing_wire_arbiter_pkg.sv
// ============================================================================
// crossing_wire_arbiter_pkg: shared FSM encoding and sizing constants.
// Revision: 1.0
// ============================================================================
`default_nettype none

package crossing_wire_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 2;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/crossing_wire_arbiter_rr_pick4.sv
// ============================================================================
// rr_pick4: combinational round-robin pick over four requesters after `last`.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick4
  import crossing_wire_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   last,
  output logic [NUM_REQ-1:0] onehot,
  output logic [TAG_W-1:0]   idx
);

  logic [TAG_W-1:0] cand;

  // Scan from lowest to highest priority so the nearest index after `last` overwrites.
  always_comb begin
    onehot = '0;
    idx    = '0;
    cand   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = last + TAG_W'(k);
      if (req[cand]) begin
        onehot       = '0;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/crossing_wire_arbiter.sv
// ============================================================================
// crossing_wire_arbiter: round-robin arbiter holding one value on a shared wire.
// Revision: 1.0
// ============================================================================
`default_nettype none

module crossing_wire_arbiter
  import crossing_wire_arbiter_pkg::*;
#(
  parameter int width = 1,
  parameter int hold  = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NUM_REQ-1:0]   REQ,
  input  logic [width-1:0]     DIN0,
  input  logic [width-1:0]     DIN1,
  input  logic [width-1:0]     DIN2,
  input  logic [width-1:0]     DIN3,
  output logic [NUM_REQ-1:0]   GNT,
  output logic [width-1:0]     WVAL,
  output logic                 WVALID,
  output logic [TAG_W-1:0]     WTAG
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(hold - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   count;
  logic [TAG_W-1:0]   last;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [TAG_W-1:0]   pick_idx;
  logic [width-1:0]   pick_din;
  logic               take;

  rr_pick4 u_pick (
    .req    (REQ),
    .last   (last),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  always_comb begin
    case (pick_idx)
      2'd0:    pick_din = DIN0;
      2'd1:    pick_din = DIN1;
      2'd2:    pick_din = DIN2;
      default: pick_din = DIN3;
    endcase
  end

  // Grants are only issued from IDLE and are suppressed while reset is held.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    GNT       = '0;
    case (state)
      IDLE: begin
        if (RST_N && (|REQ)) begin
          take      = 1'b1;
          GNT       = pick_onehot;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (count == '0) begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count  <= '0;
      WVAL   <= '0;
      WVALID <= 1'b0;
      WTAG   <= '0;
      last   <= 2'd3;
    end else if (take) begin
      WVAL   <= pick_din;
      WTAG   <= pick_idx;
      WVALID <= 1'b1;
      count  <= CNT_LOAD;
      last   <= pick_idx;
    end else if (state == HOLD) begin
      if (count != '0) begin
        count <= count - 1'b1;
      end else begin
        WVALID <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_crossing_wire_arbiter.sv
// ============================================================================
// tb_crossing_wire_arbiter: scoreboard bench with directed and random requesters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_crossing_wire_arbiter;

  localparam int W = 8;
  localparam int H = 4;

  typedef struct {
    logic [1:0]   tag;
    logic [W-1:0] val;
  } xfer_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   pend = '0;
  logic [W-1:0] pdata [4];
  logic [3:0]   gnt;
  logic [W-1:0] wval;
  logic         wvalid;
  logic [1:0]   wtag;

  logic [3:0]   nxt_pend = '0;
  logic [W-1:0] nxt_data [4];

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    free_at = 0;
  int    last_w = 3;
  bit    sticky = 1'b0;
  bit    done = 1'b0;
  xfer_t expq [$];

  int    run = 0;
  bit    aborted = 1'b0;
  bit    prev_rst = 1'b0;

  always #5 clk = ~clk;

  crossing_wire_arbiter #(.width(W), .hold(H)) dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .REQ    (pend),
    .DIN0   (pdata[0]),
    .DIN1   (pdata[1]),
    .DIN2   (pdata[2]),
    .DIN3   (pdata[3]),
    .GNT    (gnt),
    .WVAL   (wval),
    .WVALID (wvalid),
    .WTAG   (wtag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: apply queued inputs, predict the grant from the round-robin rule.
  task automatic step(input logic rst_v);
    logic [3:0] exp_gnt;
    int w;
    @(negedge clk);
    rst_n = rst_v;
    pend  = nxt_pend;
    for (int i = 0; i < 4; i++) pdata[i] = nxt_data[i];
    #1;
    exp_gnt = 4'b0;
    w = -1;
    if (rst_v && cyc >= free_at && pend != 4'b0) begin
      for (int k = 1; k <= 4; k++) begin
        if (w < 0 && pend[(last_w + k) % 4]) w = (last_w + k) % 4;
      end
      exp_gnt[w] = 1'b1;
      expq.push_back('{tag: 2'(w), val: pdata[w]});
      last_w  = w;
      free_at = cyc + H + 2;
      if (sticky) nxt_data[w] = W'($urandom);
      else        nxt_pend[w] = 1'b0;
    end
    if (!rst_v) begin
      last_w  = 3;
      free_at = cyc + 1;
    end
    check("gnt", {28'b0, gnt}, {28'b0, exp_gnt});
    cyc++;
  endtask

  // Monitor: compares each shared-wire transfer against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (done) break;
      if (prev_rst) begin
        check("reset_wvalid", {31'b0, wvalid}, 32'd0);
        check("reset_wval",   {24'b0, wval},   32'd0);
        check("reset_wtag",   {30'b0, wtag},   32'd0);
      end
      if (wvalid) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wvalid: got wvalid=1 tag=%0d expected no pending transfer (cycle %0d)", wtag, cyc);
        end else begin
          check("wtag", {30'b0, wtag}, {30'b0, expq[0].tag});
          check("wval", {24'b0, wval}, {24'b0, expq[0].val});
        end
        run++;
        if (!rst_n) aborted = 1'b1;
      end else if (run > 0) begin
        if (!aborted) check("hold_len", run, H);
        if (expq.size() > 0) void'(expq.pop_front());
        run = 0;
        aborted = 1'b0;
      end
      prev_rst = !rst_n;
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      pdata[i]    = '0;
      nxt_data[i] = '0;
    end
    repeat (3) step(1'b0);

    // Single request from requester 0.
    nxt_pend = 4'b0001;
    nxt_data[0] = 8'hA5;
    repeat (H + 4) step(1'b1);

    // Requester 2 rises while requester 0 is being held.
    nxt_pend[0] = 1'b1;
    nxt_data[0] = 8'h3C;
    step(1'b1);
    step(1'b1);
    nxt_pend[2] = 1'b1;
    nxt_data[2] = 8'h77;
    repeat (2 * H + 6) step(1'b1);

    // Contention straight out of reset.
    repeat (2) step(1'b0);
    nxt_pend = 4'b1010;
    nxt_data[1] = 8'h11;
    nxt_data[3] = 8'h33;
    repeat (2 * (H + 2) + 2) step(1'b1);

    // Reset in the second hold cycle, then a clean transfer.
    nxt_pend = 4'b0001;
    nxt_data[0] = 8'h5A;
    step(1'b1);
    step(1'b1);
    step(1'b0);
    nxt_pend = 4'b0001;
    nxt_data[0] = 8'h99;
    repeat (H + 4) step(1'b1);

    // All four requesting continuously.
    sticky = 1'b1;
    nxt_pend = 4'b1111;
    for (int i = 0; i < 4; i++) nxt_data[i] = W'($urandom);
    repeat (5 * (H + 2) + 2) step(1'b1);
    sticky = 1'b0;
    nxt_pend = 4'b0;
    repeat (H + 3) step(1'b1);

    // Random requesters with occasional resets.
    repeat (400) begin
      for (int i = 0; i < 4; i++) begin
        if (!nxt_pend[i] && $urandom_range(0, 3) == 0) begin
          nxt_pend[i] = 1'b1;
          nxt_data[i] = W'($urandom);
        end
      end
      step(($urandom_range(0, 59) != 0) ? 1'b1 : 1'b0);
    end

    nxt_pend = 4'b0;
    repeat (H + 4) step(1'b1);
    done = 1'b1;
    @(negedge clk);
    #5;
    check("drain_queue", expq.size(), 32'd0);
    check("drain_run", run, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/crossing_wire_arbiter.md
CROSSING_WIRE_ARBITER -- requirements
Module: crossing_wire_arbiter

Interface
REQ-001 The block SHALL have parameter width, default 1, giving the data width in bits of every requester input and of the shared output value.
REQ-002 The block SHALL have parameter hold, default 4, legal range 1..255, giving the number of cycles each granted value is held stable and valid.
REQ-003 Port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port RST_N, input, 1 bit: reset, synchronous, active-low.
REQ-005 Port REQ, input, 4 bits: REQ[i] high means requester i has a value pending.
REQ-006 Ports DIN0, DIN1, DIN2 and DIN3, input, width bits each: the values offered by requesters 0 to 3.
REQ-007 Port GNT, output, 4 bits: one-hot or zero; GNT[i] high means DINi is captured at the end of this cycle.
REQ-008 Port WVAL, output, width bits: the shared value, registered, driving the crossing wire.
REQ-009 Port WVALID, output, 1 bit: registered; high while WVAL is stable and valid.
REQ-010 Port WTAG, output, 2 bits: registered index of the requester that owns the current WVAL.

Function
REQ-011 The state machine SHALL have three states: IDLE, HOLD and GAP.
REQ-012 IDLE with REQ==0: remain in IDLE; GNT=0.
REQ-013 IDLE with REQ!=0: GNT SHALL be asserted combinationally for the round-robin winner k in the same cycle.
- On that edge: WVAL<=DINk, WTAG<=k, WVALID<=1, counter<=hold-1, state<=HOLD, last-winner pointer<=k.
REQ-014 Round-robin search SHALL start at index (last+1) mod 4 and wrap through all four indices; the first REQ bit found high wins.
REQ-015 HOLD: GNT=0 and WVAL/WTAG SHALL NOT change.
- counter!=0: counter decrements.
- counter==0: WVALID<=0 and state<=GAP.
REQ-016 WVALID SHALL be high for exactly hold consecutive cycles per grant.
REQ-017 GAP: GNT=0 and WVALID=0 for exactly one cycle; state<=IDLE; WVAL retains its last value.
REQ-018 Latency: a REQ seen in IDLE at cycle t gives GNT at t, WVALID high for cycles t+1 to t+hold, and the next possible GNT at t+hold+2.
REQ-019 REQ changes during HOLD or GAP SHALL have no effect until IDLE is re-entered; a requester keeps REQ and DIN stable until it sees its GNT.
REQ-020 Simultaneous requests SHALL be resolved only by REQ-014; there is no fixed priority after the first grant.
REQ-021 GNT SHALL never have more than one bit set, and SHALL be zero outside IDLE.

Reset
REQ-022 When RST_N is low at a rising edge, the block SHALL set:
- state=IDLE, counter=0;
- WVAL=0, WVALID=0, WTAG=0;
- last-winner pointer=3, so requester 0 has first priority.
REQ-023 While RST_N is low, GNT SHALL be 0.
REQ-024 A reset asserted during HOLD or GAP SHALL abort the transfer: WVALID low from the next cycle and no partial hold resumed.

Structure
REQ-025 A shared package SHALL hold the state encoding (IDLE=0, HOLD=1, GAP=2), the requester count constant (4) and the tag width (2).
REQ-026 The round-robin winner selection SHALL be one sub-module, rr_pick4: inputs req[3:0] and last[1:0]; outputs onehot[3:0] and idx[1:0]; purely combinational.
REQ-027 The counter width SHALL be 8 bits, covering hold up to 255.

Verification
REQ-028 Single request, hold=4, width=8: REQ=0001 with DIN0=0xA5 -> GNT=0001 for one cycle; WVAL=0xA5, WTAG=0 and WVALID=1 for 4 cycles; then WVALID=0 for 1 cycle.
REQ-029 All four requests held continuously, hold=2 -> grants in order 0,1,2,3,0; grant edges spaced 4 cycles apart.
REQ-030 Out-of-reset contention: REQ=1010 -> first grant goes to requester 1, the next to requester 3.
REQ-031 REQ[2] rises during HOLD of a requester-0 transfer -> no GNT until after GAP; requester 2 is granted in the first IDLE cycle.
REQ-032 RST_N low in the 2nd HOLD cycle -> the next cycle shows WVALID=0, WVAL=0 and IDLE state; REQ=0001 afterward -> a normal full-length transfer.
REQ-033 hold=1 -> WVALID high for exactly 1 cycle per grant; back-to-back grants 3 cycles apart.
